// File: rtl/mbist_read_checker.sv
// -----------------------------------------------------------------------------
// mbist_read_checker
//
// One MBIST read/compare pass over a 4-word x 4-bit SRAM. A start pulse
// latches the address order and the expected background. Four reads are then
// issued on consecutive cycles. Each read word is compared against the
// background one cycle later. The block counts mismatches and records the
// address and syndrome of the first mismatch.
//
// Ports
//   clk_i              system clock, rising edge
//   rst_i              synchronous active-high reset, has priority over start
//   start_i            one-cycle pulse that begins a pass (accepted in IDLE/DONE)
//   dir_i              0 = ascending 0..3, 1 = descending 3..0 (latched at start)
//   exp_data_i [3:0]   expected background (latched at start)
//   rd_data_i  [3:0]   SRAM read data, valid the cycle after rd_en_o=1
//   addr_o     [1:0]   SRAM read address, holds while rd_en_o=0
//   rd_en_o            SRAM read strobe
//   busy_o             high from the cycle after start until done_o rises
//   done_o             pass complete, held until the next accepted start or reset
//   pass_o             done with zero mismatches
//   fail_count_o [2:0] mismatching words in the pass, 0..4
//   first_fail_addr_o  address of the first mismatch
//   first_fail_syn_o   rd_data ^ exp_data at the first mismatch
//   state_o    [1:0]   current FSM state (0 IDLE, 1 READ, 2 DRAIN, 3 DONE)
//
// Handshake: a read is requested in every cycle where rd_en_o=1 at addr_o.
// The SRAM must present that word on rd_data_i in the following cycle. There
// is no back-pressure. start_i is a single-cycle request that is accepted only
// in IDLE or DONE and is silently dropped otherwise.
// -----------------------------------------------------------------------------
module mbist_read_checker (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       dir_i,
    input  logic [3:0] exp_data_i,
    input  logic [3:0] rd_data_i,
    output logic [1:0] addr_o,
    output logic       rd_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] fail_count_o,
    output logic [1:0] first_fail_addr_o,
    output logic [3:0] first_fail_syn_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e     state_q;
    logic [1:0] addr_q;
    logic       rd_en_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] fail_count_q;
    logic [1:0] ffa_q;
    logic [3:0] ffs_q;
    logic [1:0] rd_cnt_q;
    logic       dir_q;
    logic [3:0] exp_q;

    // Compare pipeline: the read request delayed by one cycle, aligned with rd_data_i.
    logic       cmp_valid_q;
    logic [1:0] cmp_addr_q;

    logic [3:0] syn_d;
    logic       mismatch_d;
    logic [2:0] fail_count_d;
    logic [1:0] ffa_d;
    logic [3:0] ffs_d;
    logic [1:0] addr_step_d;

    always_comb begin
        syn_d        = rd_data_i ^ exp_q;
        mismatch_d   = cmp_valid_q && (syn_d != 4'd0);
        fail_count_d = fail_count_q;
        ffa_d        = ffa_q;
        ffs_d        = ffs_q;
        if (mismatch_d) begin
            // The first mismatch of a pass is the one seen while the count is still zero.
            if (fail_count_q == 3'd0) begin
                ffa_d = cmp_addr_q;
                ffs_d = syn_d;
            end
            if (fail_count_q != 3'd4) begin
                fail_count_d = fail_count_q + 3'd1;
            end
        end
        addr_step_d = dir_q ? (addr_q - 2'd1) : (addr_q + 2'd1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= 2'd0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 3'd0;
            ffa_q        <= 2'd0;
            ffs_q        <= 4'd0;
            rd_cnt_q     <= 2'd0;
            dir_q        <= 1'b0;
            exp_q        <= 4'd0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= 2'd0;
        end else begin
            cmp_valid_q  <= rd_en_q;
            cmp_addr_q   <= addr_q;
            fail_count_q <= fail_count_d;
            ffa_q        <= ffa_d;
            ffs_q        <= ffs_d;

            case (state_q)
                S_IDLE, S_DONE: begin
                    // cmp_valid_q is always 0 here, so clearing the results cannot drop a compare.
                    if (start_i) begin
                        dir_q        <= dir_i;
                        exp_q        <= exp_data_i;
                        fail_count_q <= 3'd0;
                        ffa_q        <= 2'd0;
                        ffs_q        <= 4'd0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        rd_en_q      <= 1'b1;
                        addr_q       <= dir_i ? 2'd3 : 2'd0;
                        rd_cnt_q     <= 2'd0;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_cnt_q == 2'd3) begin
                        // The fourth read has been issued. addr_q keeps its last value.
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q   <= addr_step_d;
                        rd_cnt_q <= rd_cnt_q + 2'd1;
                    end
                end
                S_DRAIN: begin
                    // The final compare lands on this edge. pass uses the updated count.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (fail_count_d == 3'd0);
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addr_o            = addr_q;
    assign rd_en_o           = rd_en_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign fail_count_o      = fail_count_q;
    assign first_fail_addr_o = ffa_q;
    assign first_fail_syn_o  = ffs_q;
    assign state_o           = state_q;

endmodule

// File: doc/mbist_read_checker.md
MBIST_READ_CHECKER -- requirements
Module: mbist_read_checker

Interface
REQ-001 The module SHALL have a single clock domain, and reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a read/compare pass.
REQ-005 dir  input  1  address order, latched with start; 0 = ascending 0..3, 1 = descending 3..0.
REQ-006 exp_data  input  4  expected background, latched with start.
REQ-007 rd_data  input  4  SRAM read data, valid the cycle after the cycle rd_en=1.
REQ-008 addr  output  2  SRAM read address.
REQ-009 rd_en  output  1  SRAM read strobe.
REQ-010 busy  output  1  high from the cycle after start until done rises.
REQ-011 done  output  1  pass complete; held until the next accepted start or rst.
REQ-012 pass  output  1  high only while done=1 and fail_count=0.
REQ-013 fail_count  output  3  number of mismatching words in the pass, 0..4.
REQ-014 first_fail_addr  output  2  address of the first mismatch.
REQ-015 first_fail_syn  output  4  rd_data XOR exp_data at the first mismatch.

Function
REQ-016 States SHALL be IDLE, READ, DRAIN and DONE.
REQ-017 IDLE or DONE with start=1 at edge E0 SHALL do all of the following:
- latch dir and exp_data;
- clear fail_count, first_fail_addr, first_fail_syn, done and pass;
- enter READ with rd_en=1, busy=1 and addr set to the first address (0 if dir=0, 3 if dir=1).
REQ-018 READ SHALL issue exactly 4 reads on consecutive cycles (edges E0..E3), stepping addr by +1 or -1 per dir, and SHALL enter DRAIN at E4 with rd_en=0.
REQ-019 A compare pipeline SHALL register rd_en and addr one cycle (cmp_valid, cmp_addr); at each edge where cmp_valid=1, it SHALL sample rd_data and compare against latched exp_data.
REQ-020 Compares SHALL occur at edges E2..E5, one per address in issue order.
REQ-021 On mismatch, fail_count SHALL increment by 1 with no wrap; the maximum is 4.
REQ-022 On the first mismatch of a pass only, first_fail_addr SHALL be set to cmp_addr and first_fail_syn to rd_data XOR exp_data; later mismatches SHALL NOT overwrite them.
REQ-023 DRAIN SHALL perform the last compare at E5 and enter DONE with done=1 and busy=0 visible after E5, giving a start-to-done latency of 5 cycles.
REQ-024 pass SHALL be evaluated from fail_count including the E5 compare; it SHALL NOT glitch high before the final compare.
REQ-025 start asserted in READ or DRAIN SHALL be ignored, with no effect on the sequence, latches or results.
REQ-026 exp_data or dir changing mid-pass SHALL NOT affect the pass in progress.
REQ-027 rd_data SHALL be ignored whenever cmp_valid=0.
REQ-028 The state machine SHALL remain in DONE, holding all results, until start or rst; start in DONE SHALL restart per REQ-017.
REQ-029 addr SHALL hold its last value while rd_en=0.

Reset
REQ-030 On rst=1 at any clock edge, including mid-pass, the module SHALL set:
- state IDLE;
- addr=0, rd_en=0, busy=0, done=0, pass=0;
- fail_count=0, first_fail_addr=0, first_fail_syn=0;
- cmp_valid=0, latched dir=0, latched exp_data=0.
REQ-031 rst SHALL take priority over start in the same cycle.
REQ-032 After a mid-pass reset, no compare SHALL take effect, and results SHALL remain 0 until a new start.

Verification
REQ-033 The bench SHALL cover at least the following directed scenarios:
- Clean ascending pass: dir=0, exp_data=4'b0000, SRAM all 0 -> addr 0,1,2,3 with rd_en for 4 cycles; done after 5 cycles; pass=1; fail_count=0.
- Descending with faults: dir=1, exp_data=4'b1111, word2=4'b1011, word0=4'b1110 -> addr 3,2,1,0; fail_count=2; first_fail_addr=2; first_fail_syn=4'b0100; pass=0.
- All fail: exp_data=4'b0000, SRAM all 4'b1111 -> fail_count=4; first_fail_addr=0 (dir=0); first_fail_syn=4'b1111.
- Start while busy: second start at E2 -> ignored; exactly 4 rd_en cycles; done after E5.
- Reset mid-pass: rst at E2 -> next cycle all outputs 0, state IDLE; subsequent start runs a clean full pass.
- Restart from DONE: after a failing pass, start with a clean SRAM -> results cleared at the start edge; pass=1 after 5 cycles.
